// File: rtl/pipeline_register.sv
// ---------------------------------------------------------------------------
// pipeline_register
//   Generic pipeline stage register placed between consecutive stages
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a packed bundle of stage
//   signals and applies per-stage and pipeline-wide flow control.
//
// Parameters
//   WIDTH        bundle width in bits (>= 1)
//   RESET_VALUE  value loaded while rst is high
//   FLUSH_VALUE  bubble/NOP encoding loaded on a flush
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   flush_i         local flush, loads FLUSH_VALUE
//   global_flush_i  pipeline-wide flush, same effect as flush_i
//   write_en_i      local load enable (0 = hold)
//   global_stall_i  pipeline-wide stall (1 = hold)
//   data_i          bundle from the upstream stage
//   data_o          registered bundle to the downstream stage
// ---------------------------------------------------------------------------
module pipeline_register #(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter logic [WIDTH-1:0]  FLUSH_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             global_flush_i,
  input  logic             write_en_i,
  input  logic             global_stall_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic             flush;
  logic             load;

  // Either flush source kills the stage contents; a flush wins over any hold.
  assign flush = flush_i | global_flush_i;
  assign load  = write_en_i & ~global_stall_i;

  always_ff @(posedge clk) begin
    if (rst)        data_q <= RESET_VALUE;
    else if (flush) data_q <= FLUSH_VALUE;
    else if (load)  data_q <= data_i;
  end

  // Output comes straight from the register: no input-to-output path.
  assign data_o = data_q;

endmodule

// File: tb/tb_pipeline_register.sv
module tb_pipeline_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        global_flush_i;
  logic        write_en_i;
  logic        global_stall_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [7:0]  data8_o;

  int checks = 0;
  int fails  = 0;

  localparam logic [7:0] R8 = 8'hA5;
  localparam logic [7:0] F8 = 8'h13;

  // Default-parameter instance (reset and flush both zero)
  pipeline_register dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .global_flush_i(global_flush_i),
    .write_en_i(write_en_i), .global_stall_i(global_stall_i),
    .data_i(data_i), .data_o(data_o)
  );

  // Narrow instance with distinct reset/flush encodings
  pipeline_register #(.WIDTH(8), .RESET_VALUE(R8), .FLUSH_VALUE(F8)) dut8 (
    .clk(clk), .rst(rst), .flush_i(flush_i), .global_flush_i(global_flush_i),
    .write_en_i(write_en_i), .global_stall_i(global_stall_i),
    .data_i(data_i[7:0]), .data_o(data8_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; flush_i = 1'b0; global_flush_i = 1'b0;
    write_en_i = 1'b1; global_stall_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; write_en_i = 1'b1; data_i = 32'hDEADBEEF;
    tick();
    checks++;
    if (data_o !== 32'h0) begin
      fails++; $display("FAIL reset32 got=%h exp=%h", data_o, 32'h0);
    end
    checks++;
    if (data8_o !== R8) begin
      fails++; $display("FAIL reset8 got=%h exp=%h", data8_o, R8);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (data_o !== 32'h0) begin
      fails++; $display("FAIL reset_release got=%h exp=%h", data_o, 32'h0);
    end
    write_en_i = 1'b0;
    tick();
    checks++;
    if (data_o !== 32'h0) begin
      fails++; $display("FAIL reset_then_hold got=%h exp=%h", data_o, 32'h0);
    end
  endtask

  task automatic test_load();
    idle(); data_i = 32'hCAFEBABE;
    tick();
    checks++;
    if (data_o !== 32'hCAFEBABE) begin
      fails++; $display("FAIL load32 got=%h exp=%h", data_o, 32'hCAFEBABE);
    end
    checks++;
    if (data8_o !== 8'hBE) begin
      fails++; $display("FAIL load8 got=%h exp=%h", data8_o, 8'hBE);
    end
  endtask

  task automatic test_stall();
    idle(); global_stall_i = 1'b1; data_i = 32'h12345678;
    tick();
    checks++;
    if (data_o !== 32'hCAFEBABE) begin
      fails++; $display("FAIL stall_hold got=%h exp=%h", data_o, 32'hCAFEBABE);
    end
    data_i = 32'h99999999;
    tick();
    checks++;
    if (data_o !== 32'hCAFEBABE) begin
      fails++; $display("FAIL stall_hold2 got=%h exp=%h", data_o, 32'hCAFEBABE);
    end
    global_stall_i = 1'b0; data_i = 32'h12345678;
    tick();
    checks++;
    if (data_o !== 32'h12345678) begin
      fails++; $display("FAIL stall_release got=%h exp=%h", data_o, 32'h12345678);
    end
  endtask

  task automatic test_hold();
    idle(); write_en_i = 1'b0; data_i = 32'h55AA55AA;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (data_o !== 32'h12345678) begin
        fails++; $display("FAIL local_hold[%0d] got=%h exp=%h", i, data_o, 32'h12345678);
      end
    end
    write_en_i = 1'b1;
    tick();
    checks++;
    if (data_o !== 32'h55AA55AA) begin
      fails++; $display("FAIL hold_release got=%h exp=%h", data_o, 32'h55AA55AA);
    end
  endtask

  task automatic test_flush();
    logic [1:0] sel [3] = '{2'b01, 2'b10, 2'b11};
    for (int i = 0; i < 3; i++) begin
      idle(); data_i = 32'h0F0F0F0F;
      tick();
      checks++;
      if (data_o !== 32'h0F0F0F0F) begin
        fails++; $display("FAIL flush_preload[%0d] got=%h exp=%h", i, data_o, 32'h0F0F0F0F);
      end
      flush_i = sel[i][0]; global_flush_i = sel[i][1]; data_i = 32'hFFFFFFFF;
      tick();
      checks++;
      if (data_o !== 32'h0) begin
        fails++; $display("FAIL flush32[%0d] got=%h exp=%h", i, data_o, 32'h0);
      end
      checks++;
      if (data8_o !== F8) begin
        fails++; $display("FAIL flush8[%0d] got=%h exp=%h", i, data8_o, F8);
      end
    end
    idle();
  endtask

  task automatic test_priority();
    idle(); data_i = 32'h11112222;
    tick();
    checks++;
    if (data_o !== 32'h11112222) begin
      fails++; $display("FAIL prio_load got=%h exp=%h", data_o, 32'h11112222);
    end
    flush_i = 1'b1; global_stall_i = 1'b1; write_en_i = 1'b0; data_i = 32'hAAAABBBB;
    tick();
    checks++;
    if (data_o !== 32'h0) begin
      fails++; $display("FAIL prio_flush32 got=%h exp=%h", data_o, 32'h0);
    end
    checks++;
    if (data8_o !== F8) begin
      fails++; $display("FAIL prio_flush8 got=%h exp=%h", data8_o, F8);
    end
    rst = 1'b1; global_flush_i = 1'b1;
    tick();
    checks++;
    if (data8_o !== R8) begin
      fails++; $display("FAIL prio_reset8 got=%h exp=%h", data8_o, R8);
    end
    checks++;
    if (data_o !== 32'h0) begin
      fails++; $display("FAIL prio_reset32 got=%h exp=%h", data_o, 32'h0);
    end
    // Stall and local hold together still hold
    idle(); data_i = 32'h3C3C3C3C;
    tick();
    global_stall_i = 1'b1; write_en_i = 1'b0; data_i = 32'h77777777;
    tick();
    checks++;
    if (data_o !== 32'h3C3C3C3C) begin
      fails++; $display("FAIL prio_dual_hold got=%h exp=%h", data_o, 32'h3C3C3C3C);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    idle();
    for (int i = 0; i < 6; i++) begin
      v = 32'h01020304 * (i + 1) ^ 32'hA5A5_0000;
      data_i = v;
      tick();
      checks++;
      if (data_o !== v) begin
        fails++; $display("FAIL b2b32[%0d] got=%h exp=%h", i, data_o, v);
      end
      checks++;
      if (data8_o !== v[7:0]) begin
        fails++; $display("FAIL b2b8[%0d] got=%h exp=%h", i, data8_o, v[7:0]);
      end
    end
  endtask

  initial begin
    rst = 1'b0; flush_i = 1'b0; global_flush_i = 1'b0;
    write_en_i = 1'b0; global_stall_i = 1'b0; data_i = '0;
    test_reset();
    test_load();
    test_stall();
    test_hold();
    test_flush();
    test_priority();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
